// File: rtl/stepper_pkg.sv
// Shared types and constants for the stepper axis controller.
//   state_e          : controller state (idle / running a move)
//   dir_e            : travel direction, forward walks the phase index upwards
//   PhaseTable       : coil pattern {A,B,C,D} for each of the eight phase indices
//   DefaultResetPhase: phase index loaded at reset (D coil only)
package stepper_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  typedef enum logic {
    DirRev = 1'b0,
    DirFwd = 1'b1
  } dir_e;

  localparam int unsigned NumPhases         = 8;
  localparam int unsigned DefaultResetPhase = 6;

  // Entry i is the coil drive for phase index i (index 7 listed first).
  //   0:A 1:AB 2:B 3:BC 4:C 5:CD 6:D 7:DA
  localparam logic [NumPhases-1:0][3:0] PhaseTable = {
    4'b1001, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0100, 4'b1100, 4'b1000
  };

endpackage

// File: rtl/stepper_ramp_axis_if.sv
// Move-command channel into the stepper axis controller.
//   cmd_valid        : command present (master)
//   cmd_ready        : controller can take a command (slave)
//   cmd_steps        : signed step count, negative = reverse
//   cmd_start_period : initial/final (slowest) step period in clock cycles
//   cmd_min_period   : cruise (fastest) step period
//   cmd_ramp_dec     : period change per step while ramping
//   cmd_half_step    : 1 = half-step, 0 = full-step two-phase-on
interface stepper_ramp_axis_if #(
  parameter int unsigned STEP_W   = 16,
  parameter int unsigned PERIOD_W = 32
);

  logic                cmd_valid;
  logic                cmd_ready;
  logic [STEP_W-1:0]   cmd_steps;
  logic [PERIOD_W-1:0] cmd_start_period;
  logic [PERIOD_W-1:0] cmd_min_period;
  logic [PERIOD_W-1:0] cmd_ramp_dec;
  logic                cmd_half_step;

  modport master (
    output cmd_valid,
    output cmd_steps,
    output cmd_start_period,
    output cmd_min_period,
    output cmd_ramp_dec,
    output cmd_half_step,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_steps,
    input  cmd_start_period,
    input  cmd_min_period,
    input  cmd_ramp_dec,
    input  cmd_half_step,
    output cmd_ready
  );

endinterface

// File: rtl/stepper_phase_seq.sv
// Phase index register for one stepper axis.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   step_i        : advance the index by one step this cycle
//   dir_i         : direction of the advance
//   half_step_i   : 1 = move one phase, 0 = full-step (lands on two-phase-on entries)
//   index_o       : current phase index
//   coil_next_o   : coil pattern for the index being loaded at the coming edge
module stepper_phase_seq
  import stepper_pkg::*;
#(
  parameter int unsigned RESET_PHASE = DefaultResetPhase
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       step_i,
  input  dir_e       dir_i,
  input  logic       half_step_i,
  output logic [2:0] index_o,
  output logic [3:0] coil_next_o
);

  logic [2:0] index_q, index_d;
  logic [2:0] stride;

  always_comb begin
    // Full-step from a single-coil (even) index moves by one to reach a
    // two-phase-on entry; from there it moves in strides of two.
    stride  = (half_step_i || !index_q[0]) ? 3'd1 : 3'd2;
    index_d = index_q;
    if (step_i) begin
      index_d = (dir_i == DirFwd) ? (index_q + stride) : (index_q - stride);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      index_q <= 3'(RESET_PHASE);
    end else begin
      index_q <= index_d;
    end
  end

  assign index_o     = index_q;
  assign coil_next_o = PhaseTable[index_d];

endmodule

// File: rtl/stepper_ramp_axis.sv
// Single-axis stepper controller with trapezoidal speed ramp.
//   fab_clk, reset  : clock, asynchronous active-low reset
//   cmd             : move command channel (slave side), accepted only when idle
//   abort           : stop the running move before its next step
//   hold_enable     : when idle, keep the current phase energised (else coils off)
//   position        : absolute step position, wraps
//   steps_remaining : magnitude of steps still to issue
//   busy            : a move is running
//   done            : one-cycle pulse when a move ends (qualified by aborted)
//   aborted         : last move ended by abort, held until the next accept
//   motor_output    : registered coil drive {A,B,C,D}
module stepper_ramp_axis
  import stepper_pkg::*;
#(
  parameter int unsigned STEP_W      = 16,
  parameter int unsigned POS_W       = 16,
  parameter int unsigned PERIOD_W    = 32,
  parameter int unsigned RESET_PHASE = DefaultResetPhase
) (
  input  logic                 fab_clk,
  input  logic                 reset,
  stepper_ramp_axis_if.slave   cmd,
  input  logic                 abort,
  input  logic                 hold_enable,
  output logic [POS_W-1:0]     position,
  output logic [STEP_W-1:0]    steps_remaining,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [3:0]           motor_output
);

  state_e              state_q, state_d;
  dir_e                dir_q, dir_d;
  logic                half_q, half_d;
  logic [STEP_W-1:0]   rem_q, rem_d;
  logic [STEP_W-1:0]   ramp_q, ramp_d;
  logic [PERIOD_W-1:0] start_q, start_d;
  logic [PERIOD_W-1:0] min_q, min_d;
  logic [PERIOD_W-1:0] dec_q, dec_d;
  logic [PERIOD_W-1:0] cur_q, cur_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;
  logic [3:0]          motor_q, motor_d;

  logic                accept;
  logic                step;
  logic [STEP_W-1:0]   cmd_mag;
  logic [STEP_W-1:0]   rem_dec;
  logic [PERIOD_W-1:0] start_clamp, min_clamp;
  logic [PERIOD_W:0]   decel_sum;
  logic [PERIOD_W-1:0] decel_period, accel_period;
  logic [2:0]          phase_idx;
  logic [3:0]          coil_next;

  assign cmd.cmd_ready = (state_q == StIdle);
  assign accept        = cmd.cmd_valid & cmd.cmd_ready;

  assign cmd_mag     = cmd.cmd_steps[STEP_W-1] ? (STEP_W'(0) - cmd.cmd_steps) : cmd.cmd_steps;
  assign start_clamp = (cmd.cmd_start_period == '0) ? PERIOD_W'(1) : cmd.cmd_start_period;
  assign min_clamp   = (cmd.cmd_min_period == '0) ? PERIOD_W'(1) : cmd.cmd_min_period;

  // Abort wins over a step falling in the same cycle.
  assign step    = (state_q == StRun) && !abort && (cnt_q == cur_q - PERIOD_W'(1));
  assign rem_dec = rem_q - STEP_W'(1);

  // Slow-down target saturates at the start period; the extra bit catches overflow.
  assign decel_sum    = {1'b0, cur_q} + {1'b0, dec_q};
  assign decel_period = (decel_sum > {1'b0, start_q}) ? start_q : decel_sum[PERIOD_W-1:0];
  // Only used while cur_q > min_q, so the difference cannot underflow.
  assign accel_period = ((cur_q - min_q) > dec_q) ? (cur_q - dec_q) : min_q;

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    half_d    = half_q;
    rem_d     = rem_q;
    ramp_d    = ramp_q;
    start_d   = start_q;
    min_d     = min_q;
    dec_d     = dec_q;
    cur_d     = cur_q;
    cnt_d     = cnt_q;
    pos_d     = pos_q;
    done_d    = 1'b0;
    aborted_d = aborted_q;

    case (state_q)
      StIdle: begin
        if (accept) begin
          rem_d     = cmd_mag;
          dir_d     = cmd.cmd_steps[STEP_W-1] ? DirRev : DirFwd;
          half_d    = cmd.cmd_half_step;
          start_d   = start_clamp;
          min_d     = min_clamp;
          dec_d     = cmd.cmd_ramp_dec;
          cur_d     = start_clamp;
          cnt_d     = '0;
          ramp_d    = '0;
          aborted_d = 1'b0;
          if (cmd_mag == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (abort) begin
          state_d   = StIdle;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (step) begin
          cnt_d = '0;
          rem_d = rem_dec;
          pos_d = (dir_q == DirFwd) ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
          if (rem_dec == '0) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
          // ramp_q counts accel steps taken, so decel starts once that many remain.
          if (rem_dec <= ramp_q) begin
            cur_d = decel_period;
            if (ramp_q != '0) begin
              ramp_d = ramp_q - STEP_W'(1);
            end
          end else if (cur_q > min_q) begin
            cur_d  = accel_period;
            ramp_d = ramp_q + STEP_W'(1);
          end
        end else begin
          cnt_d = cnt_q + PERIOD_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A step shows its new coil at once; otherwise energise while running or holding.
  always_comb begin
    motor_d = 4'b0000;
    if (step) begin
      motor_d = coil_next;
    end else if ((state_q == StRun) || hold_enable) begin
      motor_d = PhaseTable[phase_idx];
    end
  end

  stepper_phase_seq #(
    .RESET_PHASE(RESET_PHASE)
  ) u_phase_seq (
    .clk_i       (fab_clk),
    .rst_ni      (reset),
    .step_i      (step),
    .dir_i       (dir_q),
    .half_step_i (half_q),
    .index_o     (phase_idx),
    .coil_next_o (coil_next)
  );

  always_ff @(posedge fab_clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      dir_q     <= DirFwd;
      half_q    <= 1'b0;
      rem_q     <= '0;
      ramp_q    <= '0;
      start_q   <= PERIOD_W'(1);
      min_q     <= PERIOD_W'(1);
      dec_q     <= '0;
      cur_q     <= PERIOD_W'(1);
      cnt_q     <= '0;
      pos_q     <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      motor_q   <= 4'b0000;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      half_q    <= half_d;
      rem_q     <= rem_d;
      ramp_q    <= ramp_d;
      start_q   <= start_d;
      min_q     <= min_d;
      dec_q     <= dec_d;
      cur_q     <= cur_d;
      cnt_q     <= cnt_d;
      pos_q     <= pos_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      motor_q   <= motor_d;
    end
  end

  assign position        = pos_q;
  assign steps_remaining = rem_q;
  assign busy            = (state_q == StRun);
  assign done            = done_q;
  assign aborted         = aborted_q;
  assign motor_output    = motor_q;

endmodule

// File: tb/tb_stepper_ramp_axis.sv
// Self-checking bench for stepper_ramp_axis: a schedule-based reference model
// compared every cycle, plus directed moves with hand-computed expectations.
module tb_stepper_ramp_axis;

  localparam int STEP_W   = 16;
  localparam int POS_W    = 16;
  localparam int PERIOD_W = 32;

  logic                fab_clk;
  logic                reset;
  logic                abort;
  logic                hold_enable;
  logic [POS_W-1:0]    position;
  logic [STEP_W-1:0]   steps_remaining;
  logic                busy;
  logic                done;
  logic                aborted;
  logic [3:0]          motor_output;

  stepper_ramp_axis_if #(.STEP_W(STEP_W), .PERIOD_W(PERIOD_W)) cmd_if ();

  stepper_ramp_axis #(
    .STEP_W      (STEP_W),
    .POS_W       (POS_W),
    .PERIOD_W    (PERIOD_W),
    .RESET_PHASE (6)
  ) dut (
    .fab_clk         (fab_clk),
    .reset           (reset),
    .cmd             (cmd_if),
    .abort           (abort),
    .hold_enable     (hold_enable),
    .position        (position),
    .steps_remaining (steps_remaining),
    .busy            (busy),
    .done            (done),
    .aborted         (aborted),
    .motor_output    (motor_output)
  );

  initial fab_clk = 1'b0;
  always #5 fab_clk = ~fab_clk;

  int n_pass  = 0;
  int n_total = 0;
  int edge_no = 0;

  // Reference model state.
  logic [3:0] tbl [8];
  bit         m_busy, m_done, m_aborted, m_fwd, m_half;
  int         m_idx, m_rem, m_pos;
  logic [3:0] m_motor;
  int         sched [$];   // absolute edge numbers of the remaining steps

  // Step events observed on the DUT (for the directed checks).
  int         ev_edge [$];
  logic [3:0] ev_coil [$];
  logic [POS_W-1:0] last_pos;
  int         acc;
  bit         got_done;

  logic [3:0] exp_fwd4 [4];
  logic [3:0] exp_rev3 [3];
  int         exp_ramp [10];

  function automatic void check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_no);
  endfunction

  function automatic int next_idx(input int idx, input bit fwd, input bit half);
    int d;
    d = (half || (idx % 2 == 0)) ? 1 : 2;
    return fwd ? (idx + d) % 8 : (idx + 8 - d) % 8;
  endfunction

  // Step times for a whole move, straight from the ramp rules.
  function automatic void build_sched(input int mag, input longint st, input longint mn,
                                      input longint dec, input int acc_edge);
    longint cur, t;
    int rc, rem;
    if (st < 1) st = 1;
    if (mn < 1) mn = 1;
    cur = st; rc = 0; rem = mag; t = acc_edge;
    sched.delete();
    for (int s = 0; s < mag; s++) begin
      t += cur;
      sched.push_back(int'(t));
      rem--;
      if (rem <= rc) begin
        cur = (cur + dec > st) ? st : cur + dec;
        if (rc > 0) rc--;
      end else if (cur > mn) begin
        cur = (cur - mn > dec) ? cur - dec : mn;
        rc++;
      end
    end
  endfunction

  function automatic void model_reset();
    m_busy = 0; m_done = 0; m_aborted = 0; m_fwd = 1; m_half = 0;
    m_idx = 6; m_rem = 0; m_pos = 0; m_motor = 4'b0000;
    sched.delete();
  endfunction

  // Model update for one rising edge, using the inputs held across it.
  function automatic void model_edge();
    bit was_busy, stepped;
    int s;
    if (!reset) begin
      model_reset();
      return;
    end
    was_busy = m_busy;
    stepped  = 0;
    m_done   = 0;
    if (!m_busy) begin
      if (cmd_if.cmd_valid) begin
        s = $signed(cmd_if.cmd_steps);
        m_fwd = (s >= 0);
        m_rem = (s < 0) ? -s : s;
        m_half = cmd_if.cmd_half_step;
        m_aborted = 0;
        if (m_rem == 0) m_done = 1;
        else begin
          m_busy = 1;
          build_sched(m_rem, longint'(cmd_if.cmd_start_period), longint'(cmd_if.cmd_min_period),
                      longint'(cmd_if.cmd_ramp_dec), edge_no);
        end
      end
    end else if (abort) begin
      m_busy = 0; m_done = 1; m_aborted = 1;
    end else if (sched.size() > 0 && sched[0] == edge_no) begin
      void'(sched.pop_front());
      stepped = 1;
      m_idx = next_idx(m_idx, m_fwd, m_half);
      m_pos = (m_pos + (m_fwd ? 1 : (1 << POS_W) - 1)) % (1 << POS_W);
      m_rem--;
      if (m_rem == 0) begin
        m_busy = 0; m_done = 1;
      end
    end
    if (stepped || was_busy || hold_enable) m_motor = tbl[m_idx];
    else m_motor = 4'b0000;
  endfunction

  function automatic void compare_all();
    check("busy", busy, m_busy);
    check("done", done, m_done);
    check("aborted", aborted, m_aborted);
    check("position", position, m_pos);
    check("steps_remaining", steps_remaining, m_rem);
    check("motor_output", motor_output, m_motor);
    check("cmd_ready", cmd_if.cmd_ready, !m_busy);
  endfunction

  task automatic cycle();
    @(posedge fab_clk);
    edge_no++;
    model_edge();
    @(negedge fab_clk);
    compare_all();
    if (position != last_pos) begin
      ev_edge.push_back(edge_no);
      ev_coil.push_back(motor_output);
    end
    last_pos = position;
  endtask

  task automatic drive(input int steps, input int st, input int mn, input int dec, input bit half);
    cmd_if.cmd_valid        = 1'b1;
    cmd_if.cmd_steps        = steps[STEP_W-1:0];
    cmd_if.cmd_start_period = st;
    cmd_if.cmd_min_period   = mn;
    cmd_if.cmd_ramp_dec     = dec;
    cmd_if.cmd_half_step    = half;
  endtask

  task automatic start_move(input int steps, input int st, input int mn, input int dec,
                            input bit half);
    ev_edge.delete();
    ev_coil.delete();
    drive(steps, st, mn, dec, half);
    cycle();
    acc = edge_no;
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic run_until_done(input int limit);
    got_done = 0;
    for (int n = 0; n < limit && !got_done; n++) begin
      cycle();
      if (done) got_done = 1;
    end
    check("move_ends_within_bound", got_done, 1);
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    #1;
    model_reset();
    cycle();
    reset = 1'b1;
  endtask

  initial begin
    tbl = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};
    // Forward from D walks DA, A, AB, B.
    exp_fwd4 = '{4'b1001, 4'b1000, 4'b1100, 4'b0100};
    exp_rev3 = '{4'b0011, 4'b0110, 4'b1100};
    exp_ramp = '{20, 16, 12, 8, 8, 8, 8, 12, 16, 20};

    reset = 1'b0; abort = 1'b0; hold_enable = 1'b1;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_steps = '0; cmd_if.cmd_start_period = '0;
    cmd_if.cmd_min_period = '0; cmd_if.cmd_ramp_dec = '0; cmd_if.cmd_half_step = 1'b0;
    last_pos = '0;
    model_reset();
    #1;
    check("reset_motor", motor_output, 4'b0000);
    check("reset_busy", busy, 0);
    check("reset_position", position, 0);
    repeat (3) cycle();
    reset = 1'b1;
    cycle();

    // +4 half-step, constant period 5.
    start_move(4, 5, 5, 0, 1'b1);
    run_until_done(100);
    check("fwd4_count", ev_edge.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < ev_edge.size()) begin
        check("fwd4_coil", ev_coil[i], exp_fwd4[i]);
        check("fwd4_time", ev_edge[i] - acc, 5 * (i + 1));
      end
    end
    check("fwd4_position", position, 4);
    cycle();
    check("fwd4_done_single", done, 0);

    // -3 full-step from index 6, position wraps below zero.
    reset_pulse();
    start_move(-3, 5, 5, 0, 1'b0);
    run_until_done(100);
    check("rev3_count", ev_edge.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < ev_coil.size()) check("rev3_coil", ev_coil[i], exp_rev3[i]);
    end
    check("rev3_position", position, 16'hFFFD);

    // Trapezoidal ramp.
    start_move(10, 20, 8, 4, 1'b1);
    run_until_done(400);
    check("ramp_count", ev_edge.size(), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < ev_edge.size())
        check("ramp_interval", ev_edge[i] - ((i == 0) ? acc : ev_edge[i-1]), exp_ramp[i]);
    end

    // Abort on the 3rd step strobe of a 6-step move.
    start_move(6, 4, 4, 0, 1'b1);
    while (edge_no < acc + 11) cycle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    check("abort_steps_issued", ev_edge.size(), 2);
    check("abort_remaining", steps_remaining, 4);
    check("abort_done", done, 1);
    check("abort_flag", aborted, 1);
    check("abort_busy", busy, 0);
    cycle();
    check("abort_flag_held", aborted, 1);

    // Zero-length move: done next cycle, coils untouched (index 5 = CD).
    start_move(0, 5, 5, 0, 1'b1);
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    check("zero_coil", motor_output, 4'b0011);
    check("zero_aborted_cleared", aborted, 0);
    cycle();
    check("zero_done_single", done, 0);

    // Commands while running are ignored.
    start_move(3, 4, 4, 0, 1'b1);
    drive(100, 2, 2, 0, 1'b0);
    repeat (5) cycle();
    cmd_if.cmd_valid = 1'b0;
    run_until_done(100);
    check("busy_cmd_position", position, 16'h000C);
    check("busy_cmd_remaining", steps_remaining, 0);

    // Hold release and restore.
    hold_enable = 1'b0;
    cycle();
    check("release_coils", motor_output, 4'b0000);
    hold_enable = 1'b1;
    cycle();
    check("restore_coils", motor_output, 4'b1000);

    // Async reset in the middle of a move.
    start_move(50, 3, 3, 0, 1'b1);
    repeat (10) cycle();
    #2;
    reset = 1'b0;
    #1;
    check("midreset_motor", motor_output, 4'b0000);
    check("midreset_busy", busy, 0);
    check("midreset_position", position, 0);
    check("midreset_remaining", steps_remaining, 0);
    check("midreset_done", done, 0);
    model_reset();
    cycle();
    reset = 1'b1;
    last_pos = position;

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 49) == 0) hold_enable = ~hold_enable;
      abort = ($urandom_range(0, 39) == 0);
      if (!m_busy && $urandom_range(0, 5) == 0)
        drive(int'($urandom_range(0, 24)) - 12, $urandom_range(0, 12), $urandom_range(0, 8),
              $urandom_range(0, 4), 1'($urandom_range(0, 1)));
      else if (m_busy && $urandom_range(0, 9) == 0)
        drive(int'($urandom_range(0, 24)) - 12, $urandom_range(0, 12), $urandom_range(0, 8),
              $urandom_range(0, 4), 1'($urandom_range(0, 1)));
      else
        cmd_if.cmd_valid = 1'b0;
      cycle();
    end
    abort = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
